fb_axi_regfile: RTL and testbench



---
 rtl/fb_axi_regfile.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_fb_axi_regfile.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_axi_regfile.sv
// AXI4 slave register bank: N_RW writable control registers followed by N_RO status words.
// Independent write (AW/W/B) and read (AR/R) engines; every beat addresses the next word.
module fb_axi_regfile #(
    parameter int                    ADDR_WIDTH = 40,
    parameter int                    ID_WIDTH   = 6,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(40'hA000_0000),
    parameter int                    N_RW       = 8,
    parameter int                    N_RO       = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ID_WIDTH-1:0]        s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
    input  logic [7:0]                 s_axi_awlen,
    input  logic [2:0]                 s_axi_awsize,
    input  logic [1:0]                 s_axi_awburst,
    input  logic                       s_axi_awlock,
    input  logic [3:0]                 s_axi_awcache,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    input  logic                       s_axi_wlast,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [ID_WIDTH-1:0]        s_axi_bid,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ID_WIDTH-1:0]        s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
    input  logic [7:0]                 s_axi_arlen,
    input  logic [2:0]                 s_axi_arsize,
    input  logic [1:0]                 s_axi_arburst,
    input  logic                       s_axi_arlock,
    input  logic [3:0]                 s_axi_arcache,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [ID_WIDTH-1:0]        s_axi_rid,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rlast,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [N_RW-1:0][31:0]      reg_q,
    output logic [N_RW-1:0]            reg_wr_pulse,
    input  logic [N_RO-1:0][31:0]      sts_i
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [ADDR_WIDTH-1:0] N_RW_A  = ADDR_WIDTH'(N_RW);
    localparam logic [ADDR_WIDTH-1:0] N_MAP_A = ADDR_WIDTH'(N_RW + N_RO);

    // Word index relative to register 0; callers flag addresses below the base separately.
    function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off >> 2'd2;
    endfunction

    // ---------------- write engine ----------------
    w_state_t              w_state_r;
    w_state_t              w_state_nx_s;
    logic [ID_WIDTH-1:0]   w_id_r;
    logic [ADDR_WIDTH-1:0] w_idx_r;
    logic                  w_below_r;
    logic                  w_size_err_r;
    logic                  w_slverr_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic [N_RW-1:0][31:0] reg_q_r;
    logic [N_RW-1:0]       reg_wr_pulse_r;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  b_hs_s;
    logic                  w_ok_s;

    assign aw_hs_s = s_axi_awvalid & awready_r;
    assign w_hs_s  = s_axi_wvalid & wready_r;
    assign b_hs_s  = bvalid_r & s_axi_bready;
    assign w_ok_s  = !w_below_r && !w_size_err_r && (w_idx_r < N_RW_A);

    // Write FSM next-state decode.
    always_comb begin
        w_state_nx_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_nx_s = W_DATA;
                else         w_state_nx_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && s_axi_wlast) w_state_nx_s = W_RESP;
                else                       w_state_nx_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_nx_s = W_IDLE;
                else        w_state_nx_s = W_RESP;
            end
            default: w_state_nx_s = W_IDLE;
        endcase
    end

    // Write state, handshake outputs, register storage and write strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_r      <= W_IDLE;
            w_id_r         <= {ID_WIDTH{1'b0}};
            w_idx_r        <= {ADDR_WIDTH{1'b0}};
            w_below_r      <= 1'b0;
            w_size_err_r   <= 1'b0;
            w_slverr_r     <= 1'b0;
            awready_r      <= 1'b0;
            wready_r       <= 1'b0;
            bvalid_r       <= 1'b0;
            bresp_r        <= 2'b00;
            reg_q_r        <= '0;
            reg_wr_pulse_r <= {N_RW{1'b0}};
        end else begin
            w_state_r      <= w_state_nx_s;
            awready_r      <= (w_state_nx_s == W_IDLE);
            wready_r       <= (w_state_nx_s == W_DATA);
            bvalid_r       <= (w_state_nx_s == W_RESP);
            reg_wr_pulse_r <= {N_RW{1'b0}};
            if (aw_hs_s) begin
                w_id_r       <= s_axi_awid;
                w_idx_r      <= word_idx(s_axi_awaddr);
                w_below_r    <= (s_axi_awaddr < BASE_ADDR);
                w_size_err_r <= (s_axi_awsize != 3'd2);
                w_slverr_r   <= (s_axi_awsize != 3'd2);
            end
            if (w_hs_s) begin
                w_idx_r <= w_idx_r + ADDR_WIDTH'(1);
                if (!w_ok_s) begin
                    w_slverr_r <= 1'b1;
                end
                // Error status is sticky across the burst and reported once on the B channel.
                if (s_axi_wlast) begin
                    bresp_r <= (w_slverr_r || !w_ok_s) ? 2'b10 : 2'b00;
                end
                for (int i = 0; i < N_RW; i++) begin
                    if (w_ok_s && (w_idx_r == ADDR_WIDTH'(i))) begin
                        reg_wr_pulse_r[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (s_axi_wstrb[b]) begin
                                reg_q_r[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state_r;
    r_state_t              r_state_nx_s;
    logic [ID_WIDTH-1:0]   rid_r;
    logic [ADDR_WIDTH-1:0] r_idx_r;
    logic                  r_below_r;
    logic                  r_err_r;
    logic [7:0]            r_cnt_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic [1:0]            rresp_r;
    logic                  rlast_r;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  r_load_s;
    logic [ADDR_WIDTH-1:0] rb_idx_s;
    logic                  rb_below_s;
    logic                  rb_err_s;
    logic [7:0]            rb_cnt_s;
    logic                  rb_ok_s;
    logic [31:0]           rb_mux_s;
    logic [31:0]           rb_data_s;
    logic [1:0]            rb_resp_s;

    assign ar_hs_s = s_axi_arvalid & arready_r;
    assign r_hs_s  = rvalid_r & s_axi_rready;

    // Read FSM next-state decode.
    always_comb begin
        r_state_nx_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_nx_s = R_DATA;
                else         r_state_nx_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && (r_cnt_r == 8'd0)) r_state_nx_s = R_IDLE;
                else                             r_state_nx_s = R_DATA;
            end
            default: r_state_nx_s = R_IDLE;
        endcase
    end

    // Address context of the beat to load: beat 0 comes straight from AR, later beats advance.
    always_comb begin
        if (r_state_r == R_IDLE) begin
            rb_idx_s   = word_idx(s_axi_araddr);
            rb_below_s = (s_axi_araddr < BASE_ADDR);
            rb_err_s   = (s_axi_arsize != 3'd2);
            rb_cnt_s   = s_axi_arlen;
            r_load_s   = ar_hs_s;
        end else begin
            rb_idx_s   = r_idx_r + ADDR_WIDTH'(1);
            rb_below_s = r_below_r;
            rb_err_s   = r_err_r;
            rb_cnt_s   = r_cnt_r - 8'd1;
            r_load_s   = r_hs_s && (r_cnt_r != 8'd0);
        end
    end

    // Read data mux over RW registers and status words; unmapped words read as zero.
    always_comb begin
        rb_mux_s = 32'h0000_0000;
        for (int i = 0; i < N_RW; i++) begin
            rb_mux_s = rb_mux_s | ({32{rb_idx_s == ADDR_WIDTH'(i)}} & reg_q_r[i]);
        end
        for (int i = 0; i < N_RO; i++) begin
            rb_mux_s = rb_mux_s | ({32{rb_idx_s == ADDR_WIDTH'(N_RW + i)}} & sts_i[i]);
        end
        rb_ok_s   = !rb_below_s && !rb_err_s && (rb_idx_s < N_MAP_A);
        rb_data_s = rb_ok_s ? rb_mux_s : 32'h0000_0000;
        rb_resp_s = rb_ok_s ? 2'b00 : 2'b10;
    end

    // Read state, handshake outputs and registered beat payload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_r <= R_IDLE;
            rid_r     <= {ID_WIDTH{1'b0}};
            r_idx_r   <= {ADDR_WIDTH{1'b0}};
            r_below_r <= 1'b0;
            r_err_r   <= 1'b0;
            r_cnt_r   <= 8'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= 2'b00;
            rlast_r   <= 1'b0;
        end else begin
            r_state_r <= r_state_nx_s;
            arready_r <= (r_state_nx_s == R_IDLE);
            rvalid_r  <= (r_state_nx_s == R_DATA);
            if (ar_hs_s) begin
                rid_r <= s_axi_arid;
            end
            if (r_load_s) begin
                r_idx_r   <= rb_idx_s;
                r_below_r <= rb_below_s;
                r_err_r   <= rb_err_s;
                r_cnt_r   <= rb_cnt_s;
                rdata_r   <= rb_data_s;
                rresp_r   <= rb_resp_s;
                rlast_r   <= (rb_cnt_s == 8'd0);
            end
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bid     = w_id_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rlast   = rlast_r;
    assign reg_q         = reg_q_r;
    assign reg_wr_pulse  = reg_wr_pulse_r;

    // Burst length, burst type and protection attributes have no effect on this slave.
    logic unused_s;
    assign unused_s = ^{s_axi_awlen, s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: tb/tb_fb_axi_regfile.sv
// Scoreboard bench for fb_axi_regfile: directed scenarios plus random traffic against a word-map model.
module tb_fb_axi_regfile;

    localparam logic [39:0] BASE = 40'hA000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [5:0]      s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [39:0]     s_axi_awaddr, s_axi_araddr;
    logic [7:0]      s_axi_awlen, s_axi_arlen;
    logic [2:0]      s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]      s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic            s_axi_awlock, s_axi_arlock;
    logic [3:0]      s_axi_awcache, s_axi_arcache, s_axi_wstrb;
    logic            s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic            s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [31:0]     s_axi_wdata, s_axi_rdata;
    logic [7:0][31:0] reg_q;
    logic [7:0]      reg_wr_pulse;
    logic [3:0][31:0] sts;

    fb_axi_regfile dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .sts_i(sts)
    );

    typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [5:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    b_exp_t      be;
    r_exp_t      re;
    logic [31:0] mdl [8];
    int          pulse_cnt [8];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops expected responses on each handshake and checks stall stability.
    logic        b_stall, r_stall;
    logic [31:0] r_hold;
    always @(negedge clk) begin
        if (!rstn) begin
            b_stall = 1'b0;
            r_stall = 1'b0;
        end else begin
            if (b_stall) chk("b_hold", 64'(s_axi_bvalid), 64'd1);
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(bq.size()), 64'd1);
                else begin
                    be = bq.pop_front();
                    chk("bid", 64'(s_axi_bid), 64'(be.id));
                    chk("bresp", 64'(s_axi_bresp), 64'(be.resp));
                end
            end
            b_stall = s_axi_bvalid && !s_axi_bready;
            if (r_stall) chk("r_hold_data", 64'(s_axi_rdata), 64'(r_hold));
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) chk("r_unexpected", 64'(rq.size()), 64'd1);
                else begin
                    re = rq.pop_front();
                    chk("rid", 64'(s_axi_rid), 64'(re.id));
                    chk("rdata", 64'(s_axi_rdata), 64'(re.data));
                    chk("rresp", 64'(s_axi_rresp), 64'(re.resp));
                    chk("rlast", 64'(s_axi_rlast), 64'(re.last));
                end
            end
            r_stall = s_axi_rvalid && !s_axi_rready;
            r_hold  = s_axi_rdata;
            for (int i = 0; i < 8; i++) pulse_cnt[i] += int'(reg_wr_pulse[i]);
        end
    end

    task automatic check_regs();
        for (int i = 0; i < 8; i++) chk($sformatf("reg_q[%0d]", i), 64'(reg_q[i]), 64'(mdl[i]));
    endtask

    task automatic do_write(input logic [39:0] addr, input int len, input logic [2:0] size,
                            input logic [5:0] id, input int bdelay);
        logic [39:0] bi, idx;
        logic        bad, err;
        int          n, waits;
        bad = (size != 3'd2) || (addr < BASE);
        bi  = (addr - BASE) >> 2;
        err = bad;
        for (int k = 0; k <= len; k++) begin
            idx = bi + 40'(k);
            if (!bad && idx < 40'd8) begin
                for (int b = 0; b < 4; b++)
                    if (wstb[k][b]) mdl[idx[2:0]][8*b +: 8] = wdat[k][8*b +: 8];
            end else err = 1'b1;
        end
        bq.push_back('{id, err ? 2'b10 : 2'b00});
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        s_axi_awsize = size; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 50) begin n++; @(negedge clk); end
        chk("aw_accept", 64'(s_axi_awready), 64'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        waits = 0;
        for (int k = 0; k <= len; k++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wdat[k]; s_axi_wstrb = wstb[k];
            s_axi_wlast = (k == len);
            @(negedge clk);
            while (!s_axi_wready && waits < 50) begin waits++; @(negedge clk); end
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        chk("w_no_stall", 64'(waits), 64'd0);
        repeat (bdelay) begin @(posedge clk); #1; end
        s_axi_bready = 1'b1;
        n = 0;
        while (bq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        s_axi_bready = 1'b0;
        chk("b_done", 64'(bq.size()), 64'd0);
        bq.delete();
        @(negedge clk);
        chk("b_dropped", 64'(s_axi_bvalid), 64'd0);
        check_regs();
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [39:0] addr, input int len, input logic [2:0] size,
                           input logic [5:0] id, input bit throttle);
        logic [39:0] bi, idx;
        logic        bad;
        int          n, cyc;
        r_exp_t      e;
        bad = (size != 3'd2) || (addr < BASE);
        bi  = (addr - BASE) >> 2;
        for (int k = 0; k <= len; k++) begin
            idx = bi + 40'(k);
            e.id = id; e.last = (k == len);
            if (bad || idx >= 40'd12) begin e.data = 32'h0; e.resp = 2'b10; end
            else if (idx < 40'd8) begin e.data = mdl[idx[2:0]]; e.resp = 2'b00; end
            else begin e.data = sts[idx[1:0]]; e.resp = 2'b00; end
            rq.push_back(e);
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        s_axi_arsize = size; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 50) begin n++; @(negedge clk); end
        chk("ar_accept", 64'(s_axi_arready), 64'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        chk("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
        cyc = 0;
        while (rq.size() != 0 && cyc < 200) begin
            s_axi_rready = throttle ? (cyc % 3 == 2) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        s_axi_rready = 1'b0;
        chk("r_done", 64'(rq.size()), 64'd0);
        rq.delete();
        @(negedge clk);
        chk("r_idle", 64'(s_axi_rvalid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d)", passes, checks);
        $fatal(1);
    end

    initial begin
        int p;
        logic [39:0] a;
        rstn = 1'b0;
        {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst} = '0;
        {s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awvalid} = '0;
        {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready} = '0;
        {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst} = '0;
        {s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid, s_axi_rready} = '0;
        sts = '0;
        for (int i = 0; i < 8; i++) begin mdl[i] = 32'h0; pulse_cnt[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
        chk("rst_rdata", 64'(s_axi_rdata), 64'd0);
        chk("rst_resp", 64'({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid}), 64'd0);
        chk("rst_pulse", 64'(reg_wr_pulse), 64'd0);
        check_regs();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("awready_before_edge", 64'(s_axi_awready), 64'd0);
        @(negedge clk);
        chk("awready_after_edge", 64'(s_axi_awready), 64'd1);
        chk("arready_after_edge", 64'(s_axi_arready), 64'd1);
        @(posedge clk); #1;

        // Single write then read back, with one strobe pulse on register 1.
        p = pulse_cnt[1];
        wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
        do_write(BASE + 40'h4, 0, 3'd2, 6'd1, 0);
        chk("deadbeef", 64'(reg_q[1]), 64'hDEAD_BEEF);
        chk("pulse_once", 64'(pulse_cnt[1] - p), 64'd1);
        do_read(BASE + 40'h4, 0, 3'd2, 6'd2, 1'b0);

        // Byte-strobe merge.
        wdat[0] = 32'h1122_3344; wstb[0] = 4'hF;
        do_write(BASE + 40'h8, 0, 3'd2, 6'd3, 0);
        wdat[0] = 32'hAABB_CCDD; wstb[0] = 4'b0101;
        do_write(BASE + 40'h8, 0, 3'd2, 6'd4, 1);
        chk("strobe_merge", 64'(reg_q[2]), 64'h11BB_33DD);

        // Write to a status word and read past the map.
        wdat[0] = 32'h5; wstb[0] = 4'hF;
        do_write(BASE + 40'h20, 0, 3'd2, 6'd5, 0);
        do_read(BASE + 40'h40, 0, 3'd2, 6'd6, 1'b0);

        // Burst across the RW/RO boundary with a throttled master.
        sts[0] = 32'hCAFE_0001;
        wdat[0] = 32'h77; wstb[0] = 4'hF;
        do_write(BASE + 40'h1C, 0, 3'd2, 6'd7, 0);
        do_read(BASE + 40'h1C, 1, 3'd2, 6'd8, 1'b1);

        // Four-beat write burst with a late bready.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'(k + 1); wstb[k] = 4'hF; end
        do_write(BASE, 3, 3'd2, 6'd9, 5);
        for (int k = 0; k < 4; k++) chk("burst_val", 64'(reg_q[k]), 64'(k + 1));

        // Reset in the middle of a write burst.
        s_axi_awid = 6'd10; s_axi_awaddr = BASE; s_axi_awlen = 8'd3; s_axi_awsize = 3'd2;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        chk("abort_aw", 64'(s_axi_awready), 64'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = 32'h100 + 32'(k); s_axi_wstrb = 4'hF;
            @(negedge clk);
            chk("abort_wready", 64'(s_axi_wready), 64'd1);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        rstn = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
        @(negedge clk);
        check_regs();
        chk("abort_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("abort_wready_low", 64'(s_axi_wready), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_b", 64'(s_axi_bvalid), 64'd0);
        chk("abort_idle", 64'(s_axi_awready), 64'd1);
        @(posedge clk); #1;
        wdat[0] = 32'h0BAD_F00D; wstb[0] = 4'hF;
        do_write(BASE + 40'hC, 0, 3'd2, 6'd11, 0);
        do_read(BASE + 40'hC, 0, 3'd2, 6'd12, 1'b0);

        // Random traffic over the map, its edges, and illegal sizes.
        for (int i = 0; i < 4; i++) sts[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            int w, len;
            logic [2:0] sz;
            w   = int'($urandom_range(0, 16)) - 2;
            a   = BASE + 40'(w * 4);
            a[1:0] = 2'($urandom);
            len = int'($urandom_range(0, 3));
            sz  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k <= len; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
                do_write(a, len, sz, 6'($urandom), int'($urandom_range(0, 3)));
            end else begin
                do_read(a, len, sz, 6'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
